slave_wbuf_mem: RTL and testbench
=================================

// Module: slave_wbuf_mem
// PURPOSE
// - Write-buffered memory slave. Sits directly downstream of the 2-master interconnect.
// - Consumes (valid, addr, value) writes on a valid/ready handshake.
// - Queues accepted writes in a small FIFO and commits them to an 8x3 register array
//   at a fixed drain rate, so the interconnect sees real back-pressure.
// - Array contents are exported flat for golden comparison by the bench.
// PARAMETERS
// - ADDR_W     3  address width; array depth = 2**ADDR_W
// - DATA_W     3  data width per entry
// - DEPTH      2  write FIFO entries (>=1)
// - DRAIN_CYC  3  cycles from an entry reaching FIFO head to its commit (>=1)
// PORTS
// - clk         in   1                 rising-edge clock
// - rst_n       in   1                 asynchronous reset, ACTIVE-HIGH (1 = reset)
// - valid       in   1                 write request from interconnect
// - addr        in   ADDR_W            write address
// - value       in   DATA_W            write data
// - ready       out  1                 slave can accept this cycle
// - mem_flat    out  DATA_W<<ADDR_W    entry i at [i*DATA_W +: DATA_W]
// - commit      out  1                 registered 1-cycle pulse, cycle after a commit
// - commit_cnt  out  8                 total commits, saturates at 255
// - busy        out  1                 FSM not IDLE
// BEHAVIOUR
// - Reset (async, rst_n=1):
//   - array, FIFO, counters, commit and commit_cnt all clear to 0; FSM goes to IDLE.
//   - ready is forced 0 while reset is high.
//   - Reset mid-operation discards all queued writes.
// - Handshake:
//   - A write is accepted on a rising edge with valid && ready.
//   - ready = (fifo_count < DEPTH); it depends only on registered state, never on valid.
//   - valid with ready=0 is not consumed. The master holds it; the slave does not
//     check stability.
// - No bypass:
//   - When full, ready=0 even in the cycle an entry commits.
//   - A freed slot shows ready=1 on the following cycle.
// - FIFO:
//   - circular, head/tail pointers wrap modulo DEPTH.
//   - Push and pop on the same edge (not full) keep count unchanged.
// - FSM states IDLE, WAIT:
//   - IDLE: fifo empty, busy=0, drain counter held at 0.
//     - On accept: next state WAIT, counter 0.
//   - WAIT: counter increments each cycle.
//     - On the edge where counter == DRAIN_CYC-1: write head.value to array[head.addr],
//       pop, counter <= 0, commit <= 1, commit_cnt++ (saturating).
//     - After the pop: stay in WAIT if count (including any same-edge push) > 0,
//       else go to IDLE.
// - Latency:
//   - Write accepted into an empty FIFO at edge k commits at edge k+DRAIN_CYC.
//   - mem_flat is visible after that edge.
//   - Each later entry commits DRAIN_CYC edges after the previous one.
// - Ordering: commits are strictly in acceptance order.
//   - Repeated writes to one address: last accepted wins.
// - Widths: addr indexes the full 2**ADDR_W range. No out-of-range case exists.
// - Outputs:
//   - mem_flat, commit, commit_cnt and busy are registered.
//   - ready is combinational from the registered count.
// TESTING
// - Reset release, valid=0 -> ready=1, mem_flat=0, busy=0, commit_cnt=0.
// - Single write addr=5 value=6 accepted at edge 0 -> mem_flat[17:15]=6 after edge 3;
//   commit pulses 1 cycle; busy drops.
// - 4 back-to-back writes (addr 0..3, value 1..4), valid held:
//   - ready=0 after 2 accepts.
//   - commits at edges 3, 6, 9, 12; commit_cnt=4.
// - Writes addr=2 value=7 then addr=2 value=1 -> entry 2 reads 7 after the first
//   commit, then 1 after the second.
// - Reset asserted while FIFO holds 2 entries -> no commits, mem_flat=0, ready=0
//   during reset, ready=1 after release.
// - 300 writes at full throughput -> commit_cnt saturates at 255; FIFO pointers wrap
//   with no lost or reordered writes (compare against golden array).

Source files
------------

// File: rtl/slave_wbuf_mem.sv
// Write-buffered memory slave: accepted writes are queued in a small FIFO and
// drained into a register array, one commit every DRAIN_CYC cycles.
module slave_wbuf_mem #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 3,
  parameter int DEPTH     = 2,
  parameter int DRAIN_CYC = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            value,
  output logic                         ready,
  output logic [(DATA_W<<ADDR_W)-1:0]  mem_flat,
  output logic                         commit,
  output logic [7:0]                   commit_cnt,
  output logic                         busy
);

  localparam int ENTRIES = 1 << ADDR_W;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int DC_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  logic [ADDR_W-1:0] fifo_addr_reg [DEPTH];
  logic [DATA_W-1:0] fifo_val_reg  [DEPTH];
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DC_W-1:0]   drain_reg;
  logic [DATA_W-1:0] mem_reg [ENTRIES];
  logic              commit_reg;
  logic [7:0]        commit_cnt_reg;
  state_t            state_reg;

  logic push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ready looks only at the registered count, so a slot freed by a commit
  // becomes visible one cycle later (no bypass).
  assign ready = !rst_n && (count_reg < CNT_W'(DEPTH));
  assign push  = valid && ready;
  assign pop   = (state_reg == WAIT) && (drain_reg == DC_W'(DRAIN_CYC - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_reg[i] <= '0;
        fifo_val_reg[i]  <= '0;
      end
      for (int i = 0; i < ENTRIES; i++) mem_reg[i] <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      drain_reg      <= '0;
      commit_reg     <= 1'b0;
      commit_cnt_reg <= '0;
      state_reg      <= IDLE;
    end else begin
      commit_reg <= 1'b0;
      if (push) begin
        fifo_addr_reg[tail_reg] <= addr;
        fifo_val_reg[tail_reg]  <= value;
        tail_reg                <= ptr_inc(tail_reg);
      end
      if (pop) begin
        mem_reg[fifo_addr_reg[head_reg]] <= fifo_val_reg[head_reg];
        head_reg   <= ptr_inc(head_reg);
        commit_reg <= 1'b1;
        if (commit_cnt_reg != 8'hFF) commit_cnt_reg <= commit_cnt_reg + 8'd1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

      case (state_reg)
        IDLE: begin
          drain_reg <= '0;
          if (push) state_reg <= WAIT;
        end
        WAIT: begin
          if (pop) begin
            drain_reg <= '0;
            // Last entry leaving with nothing arriving on the same edge.
            if (count_reg == CNT_W'(1) && !push) state_reg <= IDLE;
          end else begin
            drain_reg <= drain_reg + DC_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_flat
      assign mem_flat[gi*DATA_W +: DATA_W] = mem_reg[gi];
    end
  endgenerate

  assign commit     = commit_reg;
  assign commit_cnt = commit_cnt_reg;
  assign busy       = (state_reg == WAIT);

endmodule

// File: tb/tb_slave_wbuf_mem.sv
// Bench for slave_wbuf_mem: directed scenarios plus a randomized run checked
// against a queue-based model of scheduled commit times.
module tb_slave_wbuf_mem;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 3;
  localparam int DEPTH   = 2;
  localparam int D       = 3;
  localparam int ENTRIES = 1 << ADDR_W;
  localparam int FW      = DATA_W << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] value = '0;
  logic              ready;
  logic [FW-1:0]     mem_flat;
  logic              commit;
  logic [7:0]        commit_cnt;
  logic              busy;

  slave_wbuf_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DRAIN_CYC(D)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .addr(addr), .value(value),
    .ready(ready), .mem_flat(mem_flat), .commit(commit),
    .commit_cnt(commit_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model: each accepted write is stamped with the edge on which it must commit.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    int                due;
  } wr_t;

  wr_t               pend[$];
  logic [DATA_W-1:0] gold[ENTRIES];
  int                edge_n = 0;
  int                last_sched = 0;
  int                exp_cnt = 0;
  logic              exp_commit = 1'b0;

  function automatic logic [FW-1:0] gold_flat();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < ENTRIES; i++) f[i*DATA_W +: DATA_W] = gold[i];
    return f;
  endfunction

  function automatic logic model_ready();
    return (!rst_n && pend.size() < DEPTH);
  endfunction

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < ENTRIES; i++) gold[i] = '0;
    exp_cnt    = 0;
    exp_commit = 1'b0;
    last_sched = 0;
  endtask

  // One clock edge; returns 1 ns after the edge with the model advanced.
  task automatic tick();
    logic acc;
    wr_t  w;
    int   due;
    acc = valid && model_ready();
    @(posedge clk);
    edge_n++;
    exp_commit = 1'b0;
    if (!rst_n) begin
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        w = pend.pop_front();
        gold[w.a] = w.v;
        exp_commit = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
      if (acc) begin
        due = ((edge_n > last_sched) ? edge_n : last_sched) + D;
        w.a = addr; w.v = value; w.due = due;
        pend.push_back(w);
        last_sched = due;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid = 1'b0;
    model_clear();
    repeat (2) tick();
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready_low: got %b want 0", ready); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready_high: got %b want 1", ready); end
    compared++;
    if (mem_flat !== '0) begin mismatched++; $display("FAIL reset_mem: got %h want 0", mem_flat); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++;
    if (commit_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", commit_cnt); end
    compared++;
    if (commit !== 1'b0) begin mismatched++; $display("FAIL reset_commit: got %b want 0", commit); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [2:0] want_v;
    valid = 1'b1; addr = 3'd5; value = 3'd6;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      want_v = (i >= 3) ? 3'd6 : 3'd0;
      compared++;
      if (mem_flat[17:15] !== want_v) begin
        mismatched++; $display("FAIL single_mem edge+%0d: got %0d want %0d", i, mem_flat[17:15], want_v);
      end
      compared++;
      if (commit !== (i == 3)) begin
        mismatched++; $display("FAIL single_commit edge+%0d: got %b want %b", i, commit, (i == 3));
      end
      compared++;
      if (busy !== (i < 3)) begin
        mismatched++; $display("FAIL single_busy edge+%0d: got %b want %b", i, busy, (i < 3));
      end
    end
    compared++;
    if (commit_cnt !== 8'd1) begin mismatched++; $display("FAIL single_cnt: got %0d want 1", commit_cnt); end
    $display("test_single done: addr=5 value=6");
  endtask

  task automatic test_back_to_back();
    int   seen[$];
    int   first, n, cyc;
    logic will;
    first = 0; n = 0; cyc = 0;
    valid = 1'b1; addr = 3'd0; value = 3'd1;
    while (cyc < 40 && (n < 4 || seen.size() < 4)) begin
      will = valid && model_ready();
      tick();
      cyc++;
      if (will) begin
        if (n == 0) first = edge_n;
        n++;
        if (n == 2) begin
          compared++;
          if (ready !== 1'b0) begin mismatched++; $display("FAIL b2b_full_ready: got %b want 0", ready); end
        end
        if (n < 4) begin addr = 3'(n); value = 3'(n + 1); end
        else valid = 1'b0;
      end
      if (commit === 1'b1) seen.push_back(edge_n - first);
      compared++;
      if (ready !== model_ready()) begin
        mismatched++; $display("FAIL b2b_ready cyc %0d: got %b want %b", cyc, ready, model_ready());
      end
      compared++;
      if (mem_flat !== gold_flat()) begin
        mismatched++; $display("FAIL b2b_mem cyc %0d: got %h want %h", cyc, mem_flat, gold_flat());
      end
    end
    valid = 1'b0;
    compared++;
    if (seen.size() != 4) begin
      mismatched++; $display("FAIL b2b_commit_count: got %0d want 4 (cycle budget)", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (seen[i] != 3 * (i + 1)) begin
          mismatched++; $display("FAIL b2b_commit_edge %0d: got %0d want %0d", i, seen[i], 3 * (i + 1));
        end
      end
    end
    compared++;
    if (commit_cnt !== 8'd5) begin mismatched++; $display("FAIL b2b_cnt: got %0d want 5", commit_cnt); end
    $display("test_back_to_back done: commits seen=%0d", seen.size());
  endtask

  task automatic test_overwrite();
    int   n, c, cyc;
    logic will;
    logic [2:0] want_v;
    n = 0; c = 0; cyc = 0;
    valid = 1'b1; addr = 3'd2; value = 3'd7;
    while (cyc < 30 && c < 2) begin
      will = valid && model_ready();
      tick();
      cyc++;
      if (will) begin
        n++;
        if (n == 1) value = 3'd1; else valid = 1'b0;
      end
      if (commit === 1'b1) begin
        c++;
        want_v = (c == 1) ? 3'd7 : 3'd1;
        compared++;
        if (mem_flat[8:6] !== want_v) begin
          mismatched++; $display("FAIL overwrite_commit%0d: got %0d want %0d", c, mem_flat[8:6], want_v);
        end
      end
    end
    valid = 1'b0;
    compared++;
    if (c != 2) begin mismatched++; $display("FAIL overwrite_done: got %0d commits want 2 (cycle budget)", c); end
    $display("test_overwrite done");
  endtask

  task automatic test_reset_midop();
    int   cyc;
    cyc = 0;
    valid = 1'b1;
    while (cyc < 20 && pend.size() < 2) begin
      addr = 3'($urandom_range(7)); value = 3'($urandom_range(1, 7));
      tick();
      cyc++;
    end
    valid = 1'b0;
    compared++;
    if (pend.size() != 2) begin mismatched++; $display("FAIL midop_fill: got %0d queued want 2", pend.size()); end
    #2;
    rst_n = 1'b1;
    model_clear();
    #1;
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL midop_ready_rst: got %b want 0", ready); end
    compared++;
    if (mem_flat !== '0) begin mismatched++; $display("FAIL midop_mem_rst: got %h want 0", mem_flat); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL midop_busy_rst: got %b want 0", busy); end
    repeat (3) tick();
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("FAIL midop_ready_hold: got %b want 0", ready); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("FAIL midop_ready_rel: got %b want 1", ready); end
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if (commit !== 1'b0 || mem_flat !== '0 || commit_cnt !== 8'd0) begin
        mismatched++;
        $display("FAIL midop_quiet cyc %0d: commit=%b mem=%h cnt=%0d want 0/0/0", i, commit, mem_flat, commit_cnt);
      end
    end
    $display("test_reset_midop done");
  endtask

  task automatic test_saturate();
    int   n, cyc;
    logic will;
    n = 0; cyc = 0;
    valid = 1'b1; addr = 3'($urandom_range(7)); value = 3'($urandom_range(7));
    while (cyc < 2000 && (n < 300 || pend.size() > 0)) begin
      will = valid && model_ready();
      tick();
      cyc++;
      if (will) begin
        n++;
        if (n < 300) begin addr = 3'($urandom_range(7)); value = 3'($urandom_range(7)); end
        else valid = 1'b0;
      end
      compared++;
      if (mem_flat !== gold_flat() || commit !== exp_commit || commit_cnt !== 8'(exp_cnt) ||
          ready !== model_ready() || busy !== (pend.size() > 0)) begin
        mismatched++;
        $display("FAIL sat cyc %0d: mem=%h/%h commit=%b/%b cnt=%0d/%0d ready=%b/%b busy=%b/%b (got/want)",
                 cyc, mem_flat, gold_flat(), commit, exp_commit, commit_cnt, exp_cnt,
                 ready, model_ready(), busy, (pend.size() > 0));
      end
    end
    valid = 1'b0;
    compared++;
    if (n != 300 || pend.size() != 0) begin
      mismatched++; $display("FAIL sat_budget: accepted %0d want 300, pending %0d want 0", n, pend.size());
    end
    compared++;
    if (commit_cnt !== 8'd255) begin mismatched++; $display("FAIL sat_cnt: got %0d want 255", commit_cnt); end
    $display("test_saturate done: %0d writes in %0d cycles", n, cyc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overwrite();
    test_reset_midop();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
